// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Package     : nn_pkg
// Description : Shared types and constants for the accelerator host driver.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

  localparam int PIX_W = 8;   // pixel byte width, unsigned (3,5)
  localparam int ACT_W = 16;  // activation width, signed (1,15)

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ARGMAX = 3'd3,
    ST_RESULT = 3'd4,
    ST_CLEAR  = 3'd5
  } state_e;

  // Index width that stays legal (>= 1 bit) for degenerate sizes
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nn_argmax_seq.sv
`default_nettype none
// ============================================================================
// Module      : nn_argmax_seq
// Description : Sequential argmax over a stream of signed activations, one
//               per cycle. The first element (start_i) seeds the running
//               best; later elements replace it only when strictly greater,
//               so the lowest index wins ties. done_o pulses the cycle after
//               the element flagged last_i has been absorbed.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_argmax_seq
  import nn_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             valid_i,
  input  logic             last_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [ACT_W-1:0] val_i,
  output logic [ACT_W-1:0] best_val_o,
  output logic [IDX_W-1:0] best_idx_o,
  output logic             done_o
);

  logic signed [ACT_W-1:0] best_val_q;
  logic        [IDX_W-1:0] best_idx_q;
  logic                    done_q;
  logic                    w_take;

  // Seed on the first element, otherwise take only a strictly greater value
  assign w_take = start_i || ($signed(val_i) > best_val_q);

  // Running best value/index and end-of-scan flag
  always_ff @(posedge clk) begin
    if (rst) begin
      best_val_q <= '0;
      best_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= valid_i && last_i;
      if (valid_i && w_take) begin
        best_val_q <= val_i;
        best_idx_q <= idx_i;
      end
    end
  end

  assign best_val_o = best_val_q;
  assign best_idx_o = best_idx_q;
  assign done_o     = done_q;

endmodule
`default_nettype wire

// File: rtl/nn_inference_host.sv
`default_nettype none
// ============================================================================
// Module      : nn_inference_host
// Description : Host-side driver for the neural network accelerator. Loads a
//               frame of pixels over valid/ready, starts the accelerator,
//               waits for completion (with optional timeout), scans outputs
//               for the argmax and returns class/score over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_inference_host
  import nn_pkg::*;
#(
  parameter  int NUM_INPUTS     = 256,
  parameter  int NUM_OUTPUTS    = 10,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int CLS_W          = idx_width(NUM_OUTPUTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [PIX_W-1:0]            s_data,
  output logic                        nn_rst,
  output logic                        nn_ready_for_inf,
  output logic [NUM_INPUTS*PIX_W-1:0] nn_inputs,
  input  logic                        nn_fp_done,
  input  logic [NUM_OUTPUTS*ACT_W-1:0] nn_activations,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [CLS_W-1:0]            res_class,
  output logic [ACT_W-1:0]            res_score,
  output logic                        res_err
);

  localparam int               WR_W     = idx_width(NUM_INPUTS);
  localparam int               TMO_W    = idx_width(TIMEOUT_CYCLES);
  localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(NUM_INPUTS - 1);
  localparam logic [CLS_W-1:0] IDX_LAST = CLS_W'(NUM_OUTPUTS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [WR_W-1:0]  wr_idx_q;
  logic [TMO_W-1:0] tmo_q;
  logic [CLS_W-1:0] idx_q;
  logic             feed_q;
  logic             s_ready_q;
  logic             nn_rst_q;
  logic             rfi_q;
  logic             res_valid_q;
  logic [CLS_W-1:0] res_class_q;
  logic [ACT_W-1:0] res_score_q;
  logic             res_err_q;
  logic [PIX_W-1:0] buf_q [NUM_INPUTS];

  logic [ACT_W-1:0] w_act [NUM_OUTPUTS];
  logic [ACT_W-1:0] w_best_val;
  logic [CLS_W-1:0] w_best_idx;
  logic             w_arg_done;
  logic             w_hs;

  assign w_hs = (state_q == ST_LOAD) && s_valid && s_ready_q;

  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_pix
      assign nn_inputs[gi*PIX_W +: PIX_W] = buf_q[gi];
    end
    for (genvar go = 0; go < NUM_OUTPUTS; go++) begin : g_act
      assign w_act[go] = nn_activations[go*ACT_W +: ACT_W];
    end
  endgenerate

  // Capture accepted pixels; the buffer deliberately survives reset
  always_ff @(posedge clk) begin
    if (!rst && w_hs) buf_q[wr_idx_q] <= s_data;
  end

  nn_argmax_seq #(
    .IDX_W (CLS_W)
  ) u_argmax (
    .clk        (clk),
    .rst        (rst),
    .start_i    (feed_q && (idx_q == '0)),
    .valid_i    (feed_q),
    .last_i     (idx_q == IDX_LAST),
    .idx_i      (idx_q),
    .val_i      (w_act[idx_q]),
    .best_val_o (w_best_val),
    .best_idx_o (w_best_idx),
    .done_o     (w_arg_done)
  );

  // Frame sequencing FSM; every handshake/control output is registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      wr_idx_q    <= '0;
      tmo_q       <= '0;
      idx_q       <= '0;
      feed_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      nn_rst_q    <= 1'b1;
      rfi_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      res_score_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      nn_rst_q <= 1'b0;
      rfi_q    <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          s_ready_q <= 1'b1;
          if (w_hs) begin
            if (wr_idx_q == WR_LAST) begin
              wr_idx_q  <= '0;
              s_ready_q <= 1'b0;
              rfi_q     <= 1'b1;
              state_q   <= ST_START;
            end else begin
              wr_idx_q <= wr_idx_q + 1'b1;
            end
          end
        end
        ST_START: begin
          tmo_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // Done is tested first so it wins a same-cycle timeout
          if (nn_fp_done) begin
            idx_q   <= '0;
            feed_q  <= 1'b1;
            state_q <= ST_ARGMAX;
          end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST)) begin
            res_err_q   <= 1'b1;
            res_class_q <= '0;
            res_score_q <= '0;
            res_valid_q <= 1'b1;
            state_q     <= ST_RESULT;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_ARGMAX: begin
          if (feed_q) begin
            if (idx_q == IDX_LAST) feed_q <= 1'b0;
            else                   idx_q  <= idx_q + 1'b1;
          end
          if (w_arg_done) begin
            res_class_q <= w_best_idx;
            res_score_q <= w_best_val;
            res_valid_q <= 1'b1;
            state_q     <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            nn_rst_q    <= 1'b1;
            state_q     <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          s_ready_q <= 1'b1;
          state_q   <= ST_LOAD;
        end
        default: begin
          s_ready_q <= 1'b0;
          state_q   <= ST_LOAD;
        end
      endcase
    end
  end

  assign s_ready          = s_ready_q;
  assign nn_rst           = nn_rst_q;
  assign nn_ready_for_inf = rfi_q;
  assign res_valid        = res_valid_q;
  assign res_class        = res_class_q;
  assign res_score        = res_score_q;
  assign res_err          = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_nn_inference_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_inference_host
// Description : Self-checking bench for nn_inference_host with a behavioural
//               accelerator stand-in and a reference argmax model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_inference_host;

  localparam int NI    = 256;
  localparam int NO    = 10;
  localparam int TMO   = 1024;
  localparam int CLS_W = $clog2(NO);

  logic                clk = 1'b0;
  logic                rst;
  logic                s_valid;
  logic                s_ready;
  logic [7:0]          s_data;
  logic                nn_rst;
  logic                nn_ready_for_inf;
  logic [NI*8-1:0]     nn_inputs;
  logic                nn_fp_done;
  logic [NO*16-1:0]    nn_activations;
  logic                res_valid;
  logic                res_ready;
  logic [CLS_W-1:0]    res_class;
  logic [15:0]         res_score;
  logic                res_err;

  nn_inference_host #(
    .NUM_INPUTS     (NI),
    .NUM_OUTPUTS    (NO),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_data           (s_data),
    .nn_rst           (nn_rst),
    .nn_ready_for_inf (nn_ready_for_inf),
    .nn_inputs        (nn_inputs),
    .nn_fp_done       (nn_fp_done),
    .nn_activations   (nn_activations),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_class        (res_class),
    .res_score        (res_score),
    .res_err          (res_err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          act [NO];
  logic [7:0]  exp_pix [NI];
  logic [NI*8-1:0] exp_vec;
  bit          busy = 1'b0;
  logic        prev_rfi = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h required 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: find the maximum signed value, then the first index holding it
  function automatic int ref_argmax();
    int mx = -32768;
    foreach (act[i]) if (act[i] > mx) mx = act[i];
    foreach (act[i]) if (act[i] == mx) return i;
    return 0;
  endfunction

  // Protocol invariants checked every cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_rfi) check("rfi_two_cycles", nn_ready_for_inf, 1'b0);
      if (busy)     check("s_ready_busy", s_ready, 1'b0);
    end
    prev_rfi = nn_ready_for_inf;
  end

  task automatic load_frame(input string tag, input int gap_mode, input bit rand_pix);
    int k;
    int guard;
    int pulses;
    bit v;
    for (int i = 0; i < NI; i++) begin
      exp_pix[i] = rand_pix ? 8'($urandom) : 8'(i);
      exp_vec[i*8 +: 8] = exp_pix[i];
    end
    k = 0;
    guard = 0;
    while (k < NI && guard < 4*NI) begin
      @(negedge clk);
      guard++;
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = guard[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_valid = v;
      s_data  = exp_pix[k];
      if (v && s_ready) k++;
    end
    check({tag, " handshakes"}, 64'(k), 64'(NI));
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      s_valid = 1'b0;
      if (nn_ready_for_inf) begin
        pulses++;
        busy = 1'b1;
      end
    end
    check({tag, " rfi_pulses"}, 64'(pulses), 64'd1);
    check({tag, " inputs"}, 64'(nn_inputs === exp_vec), 64'd1);
  endtask

  task automatic finish_frame(input string tag, input bit give_done, input int dly, input int hold);
    int guard;
    int ecls;
    logic [63:0] ecl, esc, eer;
    for (int i = 0; i < NO; i++) nn_activations[i*16 +: 16] = 16'(act[i]);
    if (give_done) begin
      ecls = ref_argmax();
      ecl  = 64'(ecls);
      esc  = 64'(16'(act[ecls]));
      eer  = 64'd0;
      repeat (dly) @(negedge clk);
      nn_fp_done = 1'b1;
    end else begin
      ecl = 64'd0;
      esc = 64'd0;
      eer = 64'd1;
    end
    guard = 0;
    while (!res_valid && guard < 1500) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " res_valid"}, 64'(res_valid), 64'd1);
    if (!give_done) check({tag, " timeout_time"}, 64'(guard >= 1000 && guard <= 1040), 64'd1);
    check({tag, " class"}, 64'(res_class), ecl);
    check({tag, " score"}, 64'(res_score), esc);
    check({tag, " err"},   64'(res_err), eer);
    check({tag, " inputs_held"}, 64'(nn_inputs === exp_vec), 64'd1);
    repeat (hold) begin
      @(negedge clk);
      check({tag, " hold_valid"}, 64'(res_valid), 64'd1);
      check({tag, " hold_class"}, 64'(res_class), ecl);
      check({tag, " hold_score"}, 64'(res_score), esc);
      check({tag, " hold_s_ready"}, 64'(s_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready  = 1'b0;
    nn_fp_done = 1'b0;
    check({tag, " clear_nn_rst"}, 64'(nn_rst), 64'd1);
    check({tag, " clear_valid"}, 64'(res_valid), 64'd0);
    busy = 1'b0;
    @(negedge clk);
    check({tag, " load_nn_rst"}, 64'(nn_rst), 64'd0);
    check({tag, " load_s_ready"}, 64'(s_ready), 64'd1);
    check({tag, " load_err"}, 64'(res_err), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    s_valid        = 1'b0;
    s_data         = '0;
    nn_fp_done     = 1'b0;
    res_ready      = 1'b0;
    nn_activations = '0;
    repeat (3) @(negedge clk);
    check("rst nn_rst", 64'(nn_rst), 64'd1);
    check("rst s_ready", 64'(s_ready), 64'd0);
    check("rst rfi", 64'(nn_ready_for_inf), 64'd0);
    check("rst res_valid", 64'(res_valid), 64'd0);
    check("rst class", 64'(res_class), 64'd0);
    check("rst score", 64'(res_score), 64'd0);
    check("rst err", 64'(res_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel nn_rst", 64'(nn_rst), 64'd0);
    check("rel s_ready", 64'(s_ready), 64'd1);

    // Toggling valid, pixel k = k, class 7 wins clearly
    for (int i = 0; i < NO; i++) act[i] = 32'h1000;
    act[7] = 32'h7000;
    load_frame("t1", 1, 1'b0);
    finish_frame("t2", 1'b1, 384, 0);

    // Tie between indices 2 and 5, all others negative
    for (int i = 0; i < NO; i++) act[i] = 0 - int'($urandom_range(1, 32768));
    act[2] = 32'h4000;
    act[5] = 32'h4000;
    load_frame("t3", 2, 1'b1);
    finish_frame("t3", 1'b1, int'($urandom_range(10, 300)), 3);

    // Accelerator never finishes; result held 20 cycles
    load_frame("t4", 0, 1'b1);
    finish_frame("t4", 1'b0, 0, 20);

    // Reset while waiting on the accelerator
    load_frame("t6a", 2, 1'b1);
    repeat (30) @(negedge clk);
    busy = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    check("t6 rst nn_rst", 64'(nn_rst), 64'd1);
    check("t6 rst valid", 64'(res_valid), 64'd0);
    check("t6 rst s_ready", 64'(s_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t6 rel nn_rst", 64'(nn_rst), 64'd0);
    check("t6 rel s_ready", 64'(s_ready), 64'd1);
    check("t6 no_result", 64'(res_valid), 64'd0);
    for (int i = 0; i < NO; i++) act[i] = int'($urandom_range(0, 65535)) - 32768;
    load_frame("t6b", 0, 1'b1);
    finish_frame("t6b", 1'b1, 50, 1);

    // Randomized frames, with ties injected half the time
    for (int f = 0; f < 5; f++) begin
      int m;
      int j;
      for (int i = 0; i < NO; i++) act[i] = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 1) == 1) begin
        m = ref_argmax();
        j = int'($urandom_range(0, NO - 1));
        act[j] = act[m];
      end
      load_frame($sformatf("r%0d", f), int'($urandom_range(0, 2)), 1'b1);
      finish_frame($sformatf("r%0d", f), 1'b1, int'($urandom_range(6, 400)),
                   int'($urandom_range(0, 5)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
